// File: rtl/systolic_array_seq_ctrl.sv
// Sequencer for the NxN systolic MAC array: tiled matrix passes with drain,
// compress (row-reduce) sequence, abort and operand validation.
module systolic_array_seq_ctrl #(
    parameter int SIZE      = 16,
    parameter int MAC_STEPS = 2,
    parameter int TILE_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    compress,
    input  logic                    abort,
    input  logic [$clog2(SIZE)+1:0] k_len,
    input  logic [$clog2(SIZE):0]   rows_A,
    input  logic [$clog2(SIZE):0]   cols_B,
    input  logic [TILE_W-1:0]       tiles,
    output logic                    load_en,
    output logic                    mult_en,
    output logic                    acc_en,
    output logic [SIZE-1:0]         memsel_A,
    output logic [SIZE-1:0]         memsel_B,
    output logic                    next,
    output logic                    busy,
    output logic                    done,
    output logic                    comp_add,
    output logic                    comp_en,
    output logic                    comp_ld,
    output logic [TILE_W-1:0]       tile_idx,
    output logic                    err
);

    localparam int KW = $clog2(SIZE) + 2;
    localparam int RW = $clog2(SIZE) + 1;
    localparam int BW = $clog2(3 * SIZE) + 1;
    localparam int SW = $clog2(MAC_STEPS) + 1;

    localparam logic [KW-1:0] K_MAX     = KW'(2 * SIZE);
    localparam logic [RW-1:0] R_MAX     = RW'(SIZE);
    localparam logic [SW-1:0] STEP_LAST = SW'(MAC_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_TILE_NEXT,
        S_DONE,
        S_CMP_RUN,
        S_CMP_LOAD,
        S_CMP_DONE
    } state_t;

    state_t            state;
    logic [BW-1:0]     beat;
    logic [BW-1:0]     cnt;
    logic [BW-1:0]     d_q;
    logic [SW-1:0]     step;
    logic [KW-1:0]     k_q;
    logic [RW-1:0]     r_q;
    logic [RW-1:0]     c_q;
    logic [TILE_W-1:0] t_q;

    logic [BW-1:0] k_ext;
    logic [BW-1:0] r_ext;
    logic [BW-1:0] c_ext;
    logic [BW-1:0] d_new;
    logic          start_bad;
    logic          in_feed;
    logic          bit_a;
    logic          bit_b;
    logic          step_last;
    logic          feed_end;
    logic          drain_end;
    logic          pass_end;
    logic          tile_last;

    always_comb begin
        k_ext     = BW'(k_q);
        r_ext     = BW'(r_q);
        c_ext     = BW'(c_q);
        d_new     = BW'(rows_A) + BW'(cols_B);
        if (d_new != '0)
            d_new = d_new - BW'(1);
        start_bad = (k_len == '0) || (k_len > K_MAX) ||
                    (rows_A > R_MAX) || (cols_B > R_MAX);
        in_feed   = (state == S_FEED);
        bit_a     = in_feed && (beat < r_ext);
        bit_b     = in_feed && (beat < c_ext);
        step_last = (step == STEP_LAST);
        feed_end  = (beat == k_ext - BW'(1));
        drain_end = (beat == d_q - BW'(1));
        // With an empty drain the pass ends on the last feed beat.
        pass_end  = in_feed ? (feed_end && (d_q == '0)) : drain_end;
        tile_last = (tile_idx == t_q - TILE_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            beat     <= '0;
            cnt      <= '0;
            d_q      <= '0;
            step     <= '0;
            k_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            t_q      <= '0;
            load_en  <= 1'b0;
            mult_en  <= 1'b0;
            acc_en   <= 1'b0;
            memsel_A <= '0;
            memsel_B <= '0;
            next     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            comp_add <= 1'b0;
            comp_en  <= 1'b0;
            comp_ld  <= 1'b0;
            tile_idx <= '0;
            err      <= 1'b0;
        end else begin
            load_en  <= 1'b0;
            mult_en  <= 1'b0;
            acc_en   <= 1'b0;
            next     <= 1'b0;
            done     <= 1'b0;
            comp_add <= 1'b0;
            comp_en  <= 1'b0;
            comp_ld  <= 1'b0;
            err      <= 1'b0;
            if (state != S_IDLE && abort) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                memsel_A <= '0;
                memsel_B <= '0;
                beat     <= '0;
                step     <= '0;
                cnt      <= '0;
                tile_idx <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (!abort) begin
                            if (compress) begin
                                if (rows_A > R_MAX) begin
                                    err <= 1'b1;
                                end else begin
                                    r_q   <= rows_A;
                                    cnt   <= '0;
                                    busy  <= 1'b1;
                                    state <= S_CMP_RUN;
                                end
                            end else if (start) begin
                                if (start_bad) begin
                                    err <= 1'b1;
                                end else begin
                                    k_q      <= k_len;
                                    r_q      <= rows_A;
                                    c_q      <= cols_B;
                                    t_q      <= (tiles == '0) ? TILE_W'(1) : tiles;
                                    d_q      <= d_new;
                                    busy     <= 1'b1;
                                    tile_idx <= '0;
                                    beat     <= '0;
                                    step     <= '0;
                                    memsel_A <= '0;
                                    memsel_B <= '0;
                                    state    <= S_FEED;
                                end
                            end
                        end
                    end
                    S_FEED, S_DRAIN: begin
                        if (step == '0) begin
                            load_en <= 1'b1;
                            acc_en  <= 1'b1;
                        end
                        if (step_last) begin
                            mult_en  <= 1'b1;
                            step     <= '0;
                            next     <= in_feed;
                            memsel_A <= {memsel_A[SIZE-2:0], bit_a};
                            memsel_B <= {memsel_B[SIZE-2:0], bit_b};
                            if (pass_end) begin
                                beat  <= '0;
                                state <= tile_last ? S_DONE : S_TILE_NEXT;
                            end else if (in_feed && feed_end) begin
                                beat  <= '0;
                                state <= S_DRAIN;
                            end else begin
                                beat <= beat + BW'(1);
                            end
                        end else begin
                            step <= step + SW'(1);
                        end
                    end
                    S_TILE_NEXT: begin
                        // Step 0 of the next tile's first beat, no gap cycle.
                        memsel_A <= '0;
                        memsel_B <= '0;
                        tile_idx <= tile_idx + TILE_W'(1);
                        load_en  <= 1'b1;
                        acc_en   <= 1'b1;
                        beat     <= '0;
                        step     <= SW'(1);
                        state    <= S_FEED;
                    end
                    S_DONE: begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        memsel_A <= '0;
                        memsel_B <= '0;
                        beat     <= '0;
                        step     <= '0;
                        state    <= S_IDLE;
                    end
                    S_CMP_RUN: begin
                        comp_add <= 1'b1;
                        comp_en  <= 1'b1;
                        if (cnt == r_ext)
                            state <= S_CMP_LOAD;
                        else
                            cnt <= cnt + BW'(1);
                    end
                    S_CMP_LOAD: begin
                        comp_ld <= 1'b1;
                        state   <= S_CMP_DONE;
                    end
                    S_CMP_DONE: begin
                        comp_ld <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        state   <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/systolic_array_seq_ctrl.md
Name: systolic_array_seq_ctrl

Overview:
Parametrised sequencer for the NxN systolic MAC array, second generation of the array controller.
- Drives load/multiply/accumulate strobes and staircase row/column memory selects.
- Runs multi-tile matrix passes with an explicit array drain phase.
- Runs a compress (row-reduce) sequence.
- Adds a configurable MAC step count, operand validation, abort, and a per-tile index.

Parameters:
SIZE, 16, array dimension N (memsel width, max rows/cols)
MAC_STEPS, 2, clocks per MAC beat (>=2); step 0 = load/accumulate, step MAC_STEPS-1 = multiply
TILE_W, 8, width of tile count/index

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin matrix pass (sampled in IDLE)
compress  in  1  begin compress sequence (sampled in IDLE; wins over start)
abort  in  1  cancel any active operation
k_len  in  $clog2(SIZE)+2  feed beats per tile (inner dimension), legal 1..2*SIZE
rows_A  in  $clog2(SIZE)+1  active A rows, legal 0..SIZE
cols_B  in  $clog2(SIZE)+1  active B columns, legal 0..SIZE
tiles  in  TILE_W  tile passes; 0 treated as 1
load_en, mult_en, acc_en  out  1 each  MAC strobes
memsel_A, memsel_B  out  SIZE each  row/column select staircases
next  out  1  operand FIFO pop request, one pulse per feed beat
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
comp_add, comp_en, comp_ld  out  1 each  compress-unit controls
tile_idx  out  TILE_W  current tile, 0-based
err  out  1  one-cycle illegal-operand pulse

Behaviour:
- All outputs are registered. Reset (reset=0, async) forces state IDLE, all outputs 0, all counters 0.
- Priority: reset > abort > compress > start. start or compress while busy=1 is ignored.
- Cycle c = interval after rising edge c; the request is sampled at edge 0.
- States: IDLE, FEED, DRAIN, TILE_NEXT (internal, 0 cycles), DONE, CMP_RUN, CMP_LOAD, CMP_DONE.
- IDLE: all strobes, memsel and counters 0, busy=0.
  - start with k_len==0, k_len>2*SIZE, rows_A>SIZE or cols_B>SIZE: err=1 in cycle 0; stay IDLE; busy stays 0.
  - Legal start: cycle 0 has busy=1, strobes 0, tile_idx=0; enter FEED with beat=0, step=0.
- FEED/DRAIN beat (MAC_STEPS clocks):
  - Step 0: load_en=acc_en=1, others 0.
  - Intermediate steps: all strobes 0.
  - Step MAC_STEPS-1: mult_en=1.
  - The first beat's step 0 is cycle 1.
- FEED, last step of beat b (0-based):
  - next=1.
  - memsel_A <= {memsel_A[SIZE-2:0], b<rows_A}.
  - memsel_B <= {memsel_B[SIZE-2:0], b<cols_B}. memsel_B shifts its own register.
  - After beat k_len-1, go to DRAIN.
- DRAIN: D = rows_A+cols_B-1 beats (0 if both are 0). Same strobe pattern, next=0, both memsels shift in 0.
  - At the end, if tile_idx+1 < max(tiles,1): tile_idx++, memsel cleared to 0, beat=0, FEED resumes on the next cycle with no idle gap.
  - Otherwise go to DONE.
- DONE: done=1, busy=0 for one cycle, strobes 0; then IDLE. tile_idx holds until the next start.
- Single-tile busy length: 1 + (k_len+D)*MAC_STEPS cycles; done follows in the next cycle.
- Compress (compress=1 in IDLE): busy=1, counter=0, enter CMP_RUN.
  - CMP_RUN: comp_add=comp_en=1 for rows_A+1 cycles.
  - CMP_LOAD: comp_ld=1, comp_add=comp_en=0, one cycle.
  - CMP_DONE: comp_ld=1, done=1, busy=0, one cycle; then IDLE.
  - rows_A>SIZE on compress: err pulse, stay IDLE.
- abort=1 in any non-IDLE state: next cycle all outputs 0, busy=0, no done pulse, state IDLE. Counters and tile_idx cleared.
- Operand ports are sampled only at the start/compress edge and latched; later changes have no effect.
- Counter widths must hold 2*SIZE+SIZE beats without wrap.

Test Plan:
1. SIZE=4, MAC_STEPS=2, k_len=3, rows_A=2, cols_B=3, tiles=1, start -> required response:
   - busy cycles 0-14; done=1 in cycle 15.
   - mult_en 7 pulses; next 3 pulses (cycles 2,4,6).
   - memsel_A 0001,0011,0110 then 1100,1000,0000,0000.
   - memsel_B 0001,0011,0111 then 1110,1100,1000,0000.
2. Same setup with tiles=3 -> 3 back-to-back passes; tile_idx 0,1,2; memsel clears at each boundary; next 9 pulses total; single done pulse.
3. compress=1 with rows_A=3 -> comp_en/comp_add high 4 cycles, comp_ld 2 cycles, done with comp_ld in the final cycle, busy low at done.
4. Illegal operands: start with k_len=0, then start with rows_A=5 (SIZE=4) -> err pulses once each; busy never rises; no strobes.
5. abort asserted mid-FEED (cycle 5) -> cycle 6 has all outputs 0, no done pulse; a subsequent start runs a full pass normally.
6. Concurrency and reset:
   - start+compress together in IDLE -> compress sequence runs.
   - start during busy -> ignored.
   - reset asserted mid-DRAIN -> outputs 0 immediately (asynchronously, before the next edge).
